// File: rtl/ring_decode_monitor_if.sv
// Ring sample bus: a source drives qualified one-hot ring samples and the
// monitor returns the decoded index, error pulses, lock status and counters.
interface ring_decode_monitor_if #(
    parameter int CNT_W = 8
);
    logic             ring_vld;
    logic [3:0]       ring_in;
    logic [1:0]       idx;
    logic             idx_vld;
    logic             onehot_err;
    logic             seq_err;
    logic             locked;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] wrap_cnt;

    modport master (
        output ring_vld, ring_in,
        input  idx, idx_vld, onehot_err, seq_err, locked, err_cnt, wrap_cnt
    );

    modport slave (
        input  ring_vld, ring_in,
        output idx, idx_vld, onehot_err, seq_err, locked, err_cnt, wrap_cnt
    );
endinterface

// File: rtl/ring_decode_monitor.sv
// Decodes a 4-bit rotate-left one-hot ring counter, checks that each sample
// advances by exactly one position, and tracks lock plus error/wrap counts.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// UNLOCKED | no predecessor; next one-hot sample starts a run
// ACQUIRE  | counting consecutive legal advances towards LOCK_LEN
// LOCKED   | ring verified; any error drops back to UNLOCKED
module ring_decode_monitor #(
    parameter int LOCK_LEN = 4,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    ring_decode_monitor_if.slave  bus
);
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_LEN_C = 4'(LOCK_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q;
    logic [3:0]       run_q;
    logic [1:0]       idx_q;
    logic             idx_vld_q;
    logic             onehot_err_q;
    logic             seq_err_q;
    logic             locked_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] wrap_cnt_q;

    logic             is_onehot;
    logic [1:0]       dec;
    logic             legal;
    logic [3:0]       run_inc;
    logic [CNT_W-1:0] err_cnt_inc;
    logic [CNT_W-1:0] wrap_cnt_inc;

    always_comb begin
        is_onehot = 1'b0;
        dec       = 2'd0;
        case (bus.ring_in)
            4'b0001: begin is_onehot = 1'b1; dec = 2'd0; end
            4'b0010: begin is_onehot = 1'b1; dec = 2'd1; end
            4'b0100: begin is_onehot = 1'b1; dec = 2'd2; end
            4'b1000: begin is_onehot = 1'b1; dec = 2'd3; end
            default: begin is_onehot = 1'b0; dec = 2'd0; end
        endcase
    end

    // idx_q doubles as the predecessor; it is only meaningful outside UNLOCKED.
    assign legal        = (dec == (idx_q + 2'd1));
    assign run_inc      = run_q + 4'd1;
    assign err_cnt_inc  = (err_cnt_q  == CNT_MAX) ? err_cnt_q  : err_cnt_q  + CNT_ONE;
    assign wrap_cnt_inc = (wrap_cnt_q == CNT_MAX) ? wrap_cnt_q : wrap_cnt_q + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= UNLOCKED;
            run_q        <= 4'd0;
            idx_q        <= 2'd0;
            idx_vld_q    <= 1'b0;
            onehot_err_q <= 1'b0;
            seq_err_q    <= 1'b0;
            locked_q     <= 1'b0;
            err_cnt_q    <= '0;
            wrap_cnt_q   <= '0;
        end else begin
            idx_vld_q    <= 1'b0;
            onehot_err_q <= 1'b0;
            seq_err_q    <= 1'b0;
            if (bus.ring_vld) begin
                if (!is_onehot) begin
                    onehot_err_q <= 1'b1;
                    err_cnt_q    <= err_cnt_inc;
                    state_q      <= UNLOCKED;
                    run_q        <= 4'd0;
                    locked_q     <= 1'b0;
                end else begin
                    idx_q     <= dec;
                    idx_vld_q <= 1'b1;
                    case (state_q)
                        UNLOCKED: begin
                            state_q <= ACQUIRE;
                            run_q   <= 4'd0;
                        end
                        ACQUIRE: begin
                            if (legal) begin
                                run_q <= run_inc;
                                if (run_inc == LOCK_LEN_C) begin
                                    state_q  <= LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                // Restart the run from this sample; stay in ACQUIRE.
                                seq_err_q <= 1'b1;
                                err_cnt_q <= err_cnt_inc;
                                run_q     <= 4'd0;
                            end
                        end
                        LOCKED: begin
                            if (legal) begin
                                if (idx_q == 2'd3) begin
                                    wrap_cnt_q <= wrap_cnt_inc;
                                end
                            end else begin
                                seq_err_q <= 1'b1;
                                err_cnt_q <= err_cnt_inc;
                                state_q   <= UNLOCKED;
                                run_q     <= 4'd0;
                                locked_q  <= 1'b0;
                            end
                        end
                        default: begin
                            state_q  <= UNLOCKED;
                            run_q    <= 4'd0;
                            locked_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.idx        = idx_q;
    assign bus.idx_vld    = idx_vld_q;
    assign bus.onehot_err = onehot_err_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.locked     = locked_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.wrap_cnt   = wrap_cnt_q;
endmodule

// File: tb/tb_ring_decode_monitor.sv
// Directed bench for ring_decode_monitor: two instances (CNT_W 8 and 2) share
// stimulus; expected outputs go through a scoreboard queue one cycle later.
module tb_ring_decode_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ring_decode_monitor_if #(.CNT_W(8)) if8 ();
    ring_decode_monitor_if #(.CNT_W(2)) if2 ();

    ring_decode_monitor #(.LOCK_LEN(4), .CNT_W(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    ring_decode_monitor #(.LOCK_LEN(4), .CNT_W(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    typedef struct {
        logic [1:0] idx;
        logic       ivld;
        logic       oh;
        logic       sq;
        logic       lk;
        logic [7:0] err;
        logic [7:0] wrap;
        logic [1:0] err2;
        logic [1:0] wrap2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_n = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL step%0d %s: observed %0h expected %0h", step_n, tag, obs, exp);
        end
    endtask

    task automatic step(input logic vld, input logic [3:0] ring,
                        input logic [1:0] e_idx, input logic e_ivld, input logic e_oh,
                        input logic e_sq, input logic e_lk, input int e_err, input int e_wrap);
        exp_t e;
        if8.ring_vld = vld;
        if8.ring_in  = ring;
        if2.ring_vld = vld;
        if2.ring_in  = ring;
        e.idx   = e_idx;
        e.ivld  = e_ivld;
        e.oh    = e_oh;
        e.sq    = e_sq;
        e.lk    = e_lk;
        e.err   = 8'(e_err);
        e.wrap  = 8'(e_wrap);
        e.err2  = (e_err  > 3) ? 2'd3 : 2'(e_err);
        e.wrap2 = (e_wrap > 3) ? 2'd3 : 2'(e_wrap);
        sb.push_back(e);
        @(posedge clk);
        #1;
        step_n++;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL step%0d scoreboard: observed empty expected entry", step_n);
        end else begin
            e = sb.pop_front();
            chk("idx",        {6'd0, if8.idx},        {6'd0, e.idx});
            chk("idx_vld",    {7'd0, if8.idx_vld},    {7'd0, e.ivld});
            chk("onehot_err", {7'd0, if8.onehot_err}, {7'd0, e.oh});
            chk("seq_err",    {7'd0, if8.seq_err},    {7'd0, e.sq});
            chk("locked",     {7'd0, if8.locked},     {7'd0, e.lk});
            chk("err_cnt",    if8.err_cnt,            e.err);
            chk("wrap_cnt",   if8.wrap_cnt,           e.wrap);
            chk("w2_locked",  {7'd0, if2.locked},     {7'd0, e.lk});
            chk("w2_err_cnt", {6'd0, if2.err_cnt},    {6'd0, e.err2});
            chk("w2_wrap_cnt",{6'd0, if2.wrap_cnt},   {6'd0, e.wrap2});
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset overrides a valid sample.
        rst = 1'b1;
        step(1, 4'b0001, 0, 0, 0, 0, 0, 0, 0);
        step(1, 4'b0010, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Acquire lock: 5 one-hot samples, locked after the 5th.
        step(1, 4'b1000, 3, 1, 0, 0, 0, 0, 0);
        step(1, 4'b0001, 0, 1, 0, 0, 0, 0, 0);
        step(1, 4'b0010, 1, 1, 0, 0, 0, 0, 0);
        step(1, 4'b0100, 2, 1, 0, 0, 0, 0, 0);
        step(1, 4'b1000, 3, 1, 0, 0, 1, 0, 0);

        // Wraps while locked.
        step(1, 4'b0001, 0, 1, 0, 0, 1, 0, 1);
        step(1, 4'b0010, 1, 1, 0, 0, 1, 0, 1);
        step(1, 4'b0100, 2, 1, 0, 0, 1, 0, 1);
        step(1, 4'b1000, 3, 1, 0, 0, 1, 0, 1);
        step(1, 4'b0001, 0, 1, 0, 0, 1, 0, 2);
        step(1, 4'b0010, 1, 1, 0, 0, 1, 0, 2);

        // Non-one-hot while locked.
        step(1, 4'b0110, 1, 0, 1, 0, 0, 1, 2);

        // First sample after UNLOCKED has no predecessor; 3->0 in ACQUIRE is not a wrap.
        step(1, 4'b1000, 3, 1, 0, 0, 0, 1, 2);
        step(1, 4'b0001, 0, 1, 0, 0, 0, 1, 2);
        step(1, 4'b0010, 1, 1, 0, 0, 0, 1, 2);
        step(1, 4'b0100, 2, 1, 0, 0, 0, 1, 2);
        step(1, 4'b1000, 3, 1, 0, 0, 1, 1, 2);
        step(1, 4'b0001, 0, 1, 0, 0, 1, 1, 3);
        step(1, 4'b0010, 1, 1, 0, 0, 1, 1, 3);

        // Skip while locked at idx 1, then a repeat in ACQUIRE.
        step(1, 4'b1000, 3, 1, 0, 1, 0, 2, 3);
        step(1, 4'b0010, 1, 1, 0, 0, 0, 2, 3);
        step(1, 4'b0010, 1, 1, 0, 1, 0, 3, 3);
        // Run restarted inside ACQUIRE: four legal advances relock.
        step(1, 4'b0100, 2, 1, 0, 0, 0, 3, 3);
        step(1, 4'b1000, 3, 1, 0, 0, 0, 3, 3);
        step(1, 4'b0001, 0, 1, 0, 0, 0, 3, 3);
        step(1, 4'b0010, 1, 1, 0, 0, 1, 3, 3);

        // ring_vld low with garbage: everything holds.
        step(0, 4'b0000, 1, 0, 0, 0, 1, 3, 3);
        step(0, 4'b1111, 1, 0, 0, 0, 1, 3, 3);
        step(0, 4'b1000, 1, 0, 0, 0, 1, 3, 3);
        step(1, 4'b0100, 2, 1, 0, 0, 1, 3, 3);
        step(1, 4'b1000, 3, 1, 0, 0, 1, 3, 3);
        step(1, 4'b0001, 0, 1, 0, 0, 1, 3, 4);

        // Onehot errors: zero bits and multiple bits; CNT_W=2 counters saturate.
        step(1, 4'b0000, 0, 0, 1, 0, 0, 4, 4);
        step(1, 4'b1111, 0, 0, 1, 0, 0, 5, 4);
        step(1, 4'b1100, 0, 0, 1, 0, 0, 6, 4);
        step(1, 4'b0000, 0, 0, 1, 0, 0, 7, 4);
        step(1, 4'b0011, 0, 0, 1, 0, 0, 8, 4);

        // Relock, then reset mid-LOCKED.
        step(1, 4'b0001, 0, 1, 0, 0, 0, 8, 4);
        step(1, 4'b0010, 1, 1, 0, 0, 0, 8, 4);
        step(1, 4'b0100, 2, 1, 0, 0, 0, 8, 4);
        step(1, 4'b1000, 3, 1, 0, 0, 0, 8, 4);
        step(1, 4'b0001, 0, 1, 0, 0, 1, 8, 4);
        rst = 1'b1;
        step(1, 4'b0010, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Lock must be re-acquired from scratch.
        step(1, 4'b0100, 2, 1, 0, 0, 0, 0, 0);
        step(1, 4'b1000, 3, 1, 0, 0, 0, 0, 0);
        step(1, 4'b0001, 0, 1, 0, 0, 0, 0, 0);
        step(1, 4'b0010, 1, 1, 0, 0, 0, 0, 0);
        step(1, 4'b0100, 2, 1, 0, 0, 1, 0, 0);
        step(0, 4'b0000, 2, 0, 0, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ring_decode_monitor.md
RING_DECODE_MONITOR -- requirements
Module: ring_decode_monitor

Interface
REQ-001 Parameter LOCK_LEN, default 4, number of consecutive legal advances needed to declare lock (range 2..15).
REQ-002 Parameter CNT_W, default 8, width of the error and wrap counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ring_vld  input  1  qualifies ring_in as a sample this cycle.
REQ-006 ring_in  input  4  ring pattern from a 4-bit rotate-left one-hot ring counter (1000 -> 0001 -> 0010 -> 0100 -> 1000).
REQ-007 idx  output  2  binary position of the set bit in the last valid one-hot sample.
REQ-008 idx_vld  output  1  one-cycle pulse: idx updated from a one-hot sample.
REQ-009 onehot_err  output  1  one-cycle pulse: sampled ring_in was not one-hot.
REQ-010 seq_err  output  1  one-cycle pulse: one-hot sample did not advance by exactly one position.
REQ-011 locked  output  1  monitor state is LOCKED.
REQ-012 err_cnt  output  CNT_W  saturating count of onehot_err plus seq_err events.
REQ-013 wrap_cnt  output  CNT_W  saturating count of 3 -> 0 index wraps while locked.

Function
REQ-014 All outputs are registered; a sample taken at edge N is reflected on outputs after edge N (1-cycle latency).
REQ-015 Decode: 0001 -> 0, 0010 -> 1, 0100 -> 2, 1000 -> 3.
REQ-016 Legal advance: new idx = (previous idx + 1) mod 4, so 3 -> 0 is legal.
REQ-017 Any ring_in with zero bits or more than one bit set, when ring_vld = 1, is not one-hot.
REQ-018 A non-one-hot sample pulses onehot_err, holds idx, and does not pulse idx_vld.
REQ-019 A one-hot sample updates idx and pulses idx_vld.
REQ-020 A one-hot sample that is not a legal advance from the previous one-hot sample pulses seq_err; this includes a repeated value.
REQ-021 The first one-hot sample after reset, or after entering UNLOCKED, has no predecessor and never causes seq_err.
REQ-022 When ring_vld = 0, no checks run, idx is held, no pulses are produced, and the FSM and run counter hold.
REQ-023 FSM states: UNLOCKED, ACQUIRE, LOCKED.
REQ-024 UNLOCKED: the first one-hot sample moves the FSM to ACQUIRE and sets the run counter to 0.
REQ-025 ACQUIRE: each legal advance increments the run counter; on reaching LOCK_LEN the FSM moves to LOCKED.
REQ-026 ACQUIRE: a seq_err restarts the run with the current sample as predecessor, sets run = 0, and keeps the FSM in ACQUIRE.
REQ-027 ACQUIRE: an onehot_err moves the FSM to UNLOCKED and clears the predecessor.
REQ-028 LOCKED: any onehot_err or seq_err moves the FSM to UNLOCKED and clears the predecessor.
REQ-029 LOCKED: legal advances keep the FSM in LOCKED.
REQ-030 locked = 1 exactly while the FSM is in LOCKED, with the same 1-cycle latency as the other outputs.
REQ-031 err_cnt increments by 1 per cycle in which onehot_err or seq_err pulses, in any state.
REQ-032 err_cnt saturates at all-ones.
REQ-033 wrap_cnt increments on a legal 3 -> 0 advance only when the FSM is LOCKED before the sample.
REQ-034 wrap_cnt saturates at all-ones.
REQ-035 onehot_err and seq_err are never asserted in the same cycle.

Reset
REQ-036 While rst = 1 at an edge, the monitor forces: idx = 0, idx_vld = 0, onehot_err = 0, seq_err = 0, locked = 0, err_cnt = 0, wrap_cnt = 0, FSM = UNLOCKED, run counter = 0, predecessor cleared.
REQ-037 Reset overrides ring_vld and ring_in in the same cycle.
REQ-038 Reset mid-LOCKED drops locked on the next edge; lock must be re-acquired afterwards.

Verification
REQ-039 Reset release, then ring_vld = 1 with 1000, 0001, 0010, 0100, 1000 -> idx 3, 0, 1, 2, 3; idx_vld pulses each cycle; locked rises after the 5th sample (LOCK_LEN = 4); no error pulses.
REQ-040 While locked, continue with 0001, 0010, 0100, 1000, 0001 -> wrap_cnt increments to 1 then 2 on the two 3 -> 0 advances.
REQ-041 While locked, inject 0110 -> onehot_err pulses once, idx holds, locked falls, err_cnt = 1.
REQ-042 While locked at idx = 1, inject 1000 (skip) -> seq_err pulses, idx = 3, locked falls; inject repeated 0010 in ACQUIRE -> seq_err pulses, run restarts, no UNLOCKED transition.
REQ-043 Toggle ring_vld = 0 with garbage on ring_in (0000, 1111) -> no pulses, idx and locked unchanged.
REQ-044 With CNT_W = 2, inject 5 onehot errors -> err_cnt = 3 and holds; assert rst mid-run -> all outputs at reset values on the next edge.
